// File: rtl/math_seq_pkg.sv
// Shared types and helpers for the sequenced (chunk-serial) math blocks.
package math_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } subseq_state_t;

    // Counter width for a chunk index; never narrower than one bit.
    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/math_subtractor_ripple_carry.sv
// N-bit ripple-borrow subtractor: difference = a - b - borrow_in, purely combinational.
module math_subtractor_ripple_carry #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic [N-1:0] difference,
    output logic         borrow_out
);

    logic borrow;

    // NOTE: every variable written here gets a value on every path (defaults first),
    // so no latch can be inferred.
    always_comb begin
        borrow     = borrow_in;
        difference = '0;
        for (int i = 0; i < N; i++) begin
            difference[i] = a[i] ^ b[i] ^ borrow;
            borrow        = (~a[i] & (b[i] | borrow)) | (b[i] & borrow);
        end
        borrow_out = borrow;
    end

endmodule

// File: rtl/math_subtractor_multiword_seq.sv
// Multi-precision subtractor that reuses one N-bit ripple subtractor, one chunk per
// cycle LSB first, with the inter-chunk borrow held in a register.
module math_subtractor_multiword_seq
    import math_seq_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int CHUNKS = 4,
    localparam int W      = N * CHUNKS
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_borrow_in,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_difference,
    output logic         o_borrow_out,
    output logic         o_zero,
    output logic         o_busy
);

    localparam int            CW   = cnt_width(CHUNKS);
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    subseq_state_t state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          borrow_reg;
    logic          zero_acc;

    logic [N-1:0]  chunk_a;
    logic [N-1:0]  chunk_b;
    logic [N-1:0]  chunk_diff;
    logic          chunk_borrow;
    logic          chunk_zero;

    // Select the operand chunk addressed by the counter.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (cnt == CW'(i)) begin
                chunk_a = a_reg[i*N +: N];
                chunk_b = b_reg[i*N +: N];
            end
        end
    end

    math_subtractor_ripple_carry #(.N(N)) u_sub (
        .a          (chunk_a),
        .b          (chunk_b),
        .borrow_in  (borrow_reg),
        .difference (chunk_diff),
        .borrow_out (chunk_borrow)
    );

    assign chunk_zero = (chunk_diff == '0);

    // Handshake flags come straight from the state register: no input-to-output path.
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: the operand registers are reset too; an aborted operation must
            // leave no residue behind, and these are plain flops, not a RAM.
            state        <= IDLE;
            cnt          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            borrow_reg   <= 1'b0;
            zero_acc     <= 1'b0;
            o_difference <= '0;
            o_borrow_out <= 1'b0;
            o_zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        a_reg      <= i_a;
                        b_reg      <= i_b;
                        borrow_reg <= i_borrow_in;
                        cnt        <= '0;
                        zero_acc   <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < CHUNKS; i++) begin
                        if (cnt == CW'(i)) o_difference[i*N +: N] <= chunk_diff;
                    end
                    borrow_reg <= chunk_borrow;
                    zero_acc   <= zero_acc & chunk_zero;
                    if (cnt == LAST) begin
                        o_borrow_out <= chunk_borrow;
                        o_zero       <= zero_acc & chunk_zero;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
